// File: rtl/rq_add_arbiter_if.sv
// Handshake bundle between the two coefficient fetch units, the arbiter and the
// mod-q adder. slave = arbiter side, master = surrounding fabric / testbench.
interface rq_add_arbiter_if #(
  parameter int W = 13
);
  logic         req0, req1;
  logic         gnt0, gnt1;
  logic [W-1:0] in1_coef, in2_coef;
  logic         in1_valid, in2_valid;
  logic         in1_ready, in2_ready;
  logic         sel;
  logic [W-1:0] out_coef;
  logic         out_valid, out_ready;
  logic         busy, done;

  modport slave (
    input  req0, req1, in1_coef, in2_coef, in1_valid, in2_valid, out_ready,
    output gnt0, gnt1, in1_ready, in2_ready, sel, out_coef, out_valid, busy, done
  );

  modport master (
    output req0, req1, in1_coef, in2_coef, in1_valid, in2_valid, out_ready,
    input  gnt0, gnt1, in1_ready, in2_ready, sel, out_coef, out_valid, busy, done
  );
endinterface

// File: rtl/rq_add_arbiter.sv
// Burst arbiter sharing the Rq coefficient path between two polynomial sources.
// Define RQ_ADD_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to requester 0.
module rq_add_arbiter #(
  parameter int W       = 13,
  parameter int N_COEFF = 701
) (
  input  logic          clk,
  input  logic          rst,
  rq_add_arbiter_if.slave bus
);
  localparam int            CW   = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_COEFF - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t        state, state_d;
  logic          gnt0, gnt0_d, gnt1, gnt1_d;
  logic          sel, sel_d;
  logic          out_valid, out_valid_d;
  logic [W-1:0]  out_coef, out_coef_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          done, done_d;

  logic          win0, win1;
  logic          out_free;
  logic          rdy0, rdy1;
  logic          acc;
  logic [W-1:0]  src_coef;

`ifdef RQ_ADD_ARB_RR_EN
  // ptr remembers the last winner; on a tie the other side goes next.
  logic ptr, ptr_d;
  assign win1 = bus.req1 & (~bus.req0 | ~ptr);
`else
  assign win1 = bus.req1 & ~bus.req0;
`endif
  assign win0 = bus.req0 & ~win1;

  // Ready never depends on the input valids, only on state/grant/output slot.
  assign out_free = ~out_valid | bus.out_ready;
  assign rdy0     = (state == BURST) & gnt0 & out_free;
  assign rdy1     = (state == BURST) & gnt1 & out_free;
  assign acc      = (rdy0 & bus.in1_valid) | (rdy1 & bus.in2_valid);
  assign src_coef = sel ? bus.in2_coef : bus.in1_coef;

  always_comb begin
    state_d     = state;
    gnt0_d      = gnt0;
    gnt1_d      = gnt1;
    sel_d       = sel;
    cnt_d       = cnt;
    done_d      = 1'b0;
    out_valid_d = out_valid;
    out_coef_d  = out_coef;
`ifdef RQ_ADD_ARB_RR_EN
    ptr_d       = ptr;
`endif

    // Refill wins over drain so back-to-back transfers sustain one per cycle.
    if (acc) begin
      out_valid_d = 1'b1;
      out_coef_d  = src_coef;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state)
      IDLE: begin
        if (win0 | win1) begin
          gnt0_d  = win0;
          gnt1_d  = win1;
          sel_d   = win1;
          cnt_d   = '0;
          state_d = BURST;
`ifdef RQ_ADD_ARB_RR_EN
          ptr_d   = win1;
`endif
        end
      end
      BURST: begin
        if (acc) begin
          cnt_d = cnt + CW'(1);
          if (cnt == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          done_d  = 1'b1;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      sel       <= 1'b0;
      cnt       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_coef  <= '0;
`ifdef RQ_ADD_ARB_RR_EN
      // "Last winner = 1" so requester 0 takes the first tie.
      ptr       <= 1'b1;
`endif
    end else begin
      state     <= state_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      sel       <= sel_d;
      cnt       <= cnt_d;
      done      <= done_d;
      out_valid <= out_valid_d;
      out_coef  <= out_coef_d;
`ifdef RQ_ADD_ARB_RR_EN
      ptr       <= ptr_d;
`endif
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.sel       = sel;
  assign bus.in1_ready = rdy0;
  assign bus.in2_ready = rdy1;
  assign bus.out_coef  = out_coef;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done;
endmodule
